// File: rtl/heartbeat_sample_ctrl.sv
// heartbeat_sample_ctrl: synchronizes the raw beat level, measures
// beat-to-beat intervals in 1 ms ticks with refractory filtering and
// timeout detection, queues results in a small FIFO, and presents them
// to the processor under a four-phase RDY/ACK handshake.
module heartbeat_sample_ctrl #(
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned REFRACTORY_MS = 250,
    parameter int unsigned TIMEOUT_MS    = 3000,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        beat_in,
    input  logic        IO_READ_ACK,
    output logic [31:0] IO_HEARTBEAT,
    output logic        IO_READ_RDY,
    output logic        fifo_full
);

    localparam int unsigned TICK_DIV = CLK_HZ / 1000;
    localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned CW       = AW + 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0]   REFR     = 16'(REFRACTORY_MS);
    localparam logic [15:0]   TMO      = 16'(TIMEOUT_MS);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, PRESENT, WAIT_REL} state_t;

    logic          sync1, sync2, sync3, beat_edge;
    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic [15:0]   ms_cnt;
    logic          armed, drop_flag;
    logic          arm, accept, timeout_evt, push, do_push, drop, pop;
    logic [17:0]   push_data;
    logic [17:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          full, empty;
    logic [17:0]   head;
    state_t        state, state_next;
    logic          rdy_next;
    logic [31:0]   hb_next;

    // Two-flop synchronizer plus a registered rising-edge pulse.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
            beat_edge <= 1'b0;
        end else begin
            sync1     <= beat_in;
            sync2     <= sync1;
            sync3     <= sync2;
            beat_edge <= sync2 & ~sync3;
        end
    end

    assign tick = (pre_cnt == PRE_LAST);

    // Millisecond prescaler.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) pre_cnt <= '0;
        else          pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end

    // An edge landing on the cycle ms_cnt hits the limit wins over the timeout.
    assign arm         = !armed && beat_edge;
    assign accept      = armed && beat_edge && (ms_cnt >= REFR);
    assign timeout_evt = armed && (ms_cnt == TMO) && !accept;
    assign push        = accept || timeout_evt;
    assign push_data   = {timeout_evt, drop_flag, ms_cnt};

    // Interval counter and armed flag; the tick of the clearing cycle counts
    // toward the new interval so N ticks between edges reads back as N.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ms_cnt <= '0;
            armed  <= 1'b0;
        end else begin
            if (arm || accept)
                ms_cnt <= tick ? 16'd1 : 16'd0;
            else if (tick && (ms_cnt < TMO))
                ms_cnt <= ms_cnt + 16'd1;

            if (arm)              armed <= 1'b1;
            else if (timeout_evt) armed <= 1'b0;
        end
    end

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign head    = mem[rd_ptr];

    // Occupancy bookkeeping for simultaneous push/pop.
    always_comb begin
        count_next = count;
        case ({do_push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // FIFO storage (data only, no reset needed).
    always_ff @(posedge HCLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // FIFO pointers, count, full status and sticky drop flag.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_full <= 1'b0;
            drop_flag <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count     <= count_next;
            fifo_full <= (count_next == DEPTH_C);
            if (drop)         drop_flag <= 1'b1;
            else if (do_push) drop_flag <= 1'b0;
        end
    end

    // Handshake state and registered outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state        <= IDLE;
            IO_READ_RDY  <= 1'b0;
            IO_HEARTBEAT <= '0;
        end else begin
            state        <= state_next;
            IO_READ_RDY  <= rdy_next;
            IO_HEARTBEAT <= hb_next;
        end
    end

    // Handshake next-state, output and pop decode.
    always_comb begin
        state_next = state;
        rdy_next   = IO_READ_RDY;
        hb_next    = IO_HEARTBEAT;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                rdy_next = 1'b0;
                if (!empty && !IO_READ_ACK) begin
                    state_next = PRESENT;
                    rdy_next   = 1'b1;
                    hb_next    = {head[17], head[16], 14'b0, head[15:0]};
                end
            end
            PRESENT: begin
                rdy_next = 1'b1;
                if (IO_READ_ACK) begin
                    pop        = 1'b1;
                    rdy_next   = 1'b0;
                    state_next = WAIT_REL;
                end
            end
            WAIT_REL: begin
                rdy_next = 1'b0;
                if (!IO_READ_ACK) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                rdy_next   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_heartbeat_sample_ctrl.sv
// Directed bench for heartbeat_sample_ctrl with a 1 ms = 1 cycle tick.
module tb_heartbeat_sample_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        beat_in;
    logic        IO_READ_ACK;
    logic [31:0] IO_HEARTBEAT;
    logic        IO_READ_RDY;
    logic        fifo_full;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc    = 0;

    typedef struct {
        int unsigned g1;   // second beat offset from the arming beat
        int unsigned g2;   // optional third beat offset, 0 = none
        logic [31:0] exp;  // the single expected entry
    } vec_t;

    heartbeat_sample_ctrl #(
        .CLK_HZ(1000),
        .REFRACTORY_MS(250),
        .TIMEOUT_MS(3000),
        .FIFO_DEPTH(4)
    ) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .beat_in(beat_in),
        .IO_READ_ACK(IO_READ_ACK),
        .IO_HEARTBEAT(IO_HEARTBEAT),
        .IO_READ_RDY(IO_READ_RDY),
        .fifo_full(fifo_full)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge HCLK);
    endtask

    task automatic do_reset();
        IO_READ_ACK = 1'b0;
        beat_in     = 1'b0;
        HRESETn     = 1'b0;
        tick(3);
        HRESETn     = 1'b1;
        tick(2);
    endtask

    task automatic beat_at(input int unsigned t);
        while (cyc < t) @(negedge HCLK);
        beat_in = 1'b1;
        tick(3);
        beat_in = 1'b0;
    endtask

    task automatic wait_rdy(input string name, input int unsigned max);
        int unsigned n = 0;
        while (!IO_READ_RDY && n < max) begin
            @(negedge HCLK);
            n++;
        end
        check(name, 32'(IO_READ_RDY), 32'd1);
    endtask

    task automatic ack_entry(input string name);
        IO_READ_ACK = 1'b1;
        @(negedge HCLK);
        check(name, 32'(IO_READ_RDY), 32'd0);
        IO_READ_ACK = 1'b0;
        tick(2);
    endtask

    initial begin
        vec_t        vecs[6];
        int unsigned t0;
        int unsigned t1;
        logic        seen;

        vecs[0] = '{g1: 800,  g2: 0,   exp: 32'h0000_0320};
        vecs[1] = '{g1: 100,  g2: 900, exp: 32'h0000_0384};
        vecs[2] = '{g1: 250,  g2: 0,   exp: 32'h0000_00FA};
        vecs[3] = '{g1: 249,  g2: 600, exp: 32'h0000_0258};
        vecs[4] = '{g1: 2999, g2: 0,   exp: 32'h0000_0BB7};
        vecs[5] = '{g1: 3000, g2: 0,   exp: 32'h0000_0BB8};

        // Reset values
        HRESETn     = 1'b0;
        beat_in     = 1'b0;
        IO_READ_ACK = 1'b0;
        tick(3);
        check("rst_hb",   IO_HEARTBEAT,        32'h0);
        check("rst_rdy",  32'(IO_READ_RDY),    32'd0);
        check("rst_full", 32'(fifo_full),      32'd0);
        HRESETn = 1'b1;
        tick(2);

        // Interval vectors: one entry each
        for (int i = 0; i < 6; i++) begin
            do_reset();
            t0 = cyc + 5;
            beat_at(t0);
            beat_at(t0 + vecs[i].g1);
            if (vecs[i].g2 != 0) beat_at(t0 + vecs[i].g2);
            wait_rdy($sformatf("vec%0d_rdy", i), 20);
            check($sformatf("vec%0d_data", i), IO_HEARTBEAT, vecs[i].exp);
            ack_entry($sformatf("vec%0d_ack", i));
            tick(20);
            check($sformatf("vec%0d_single", i), 32'(IO_READ_RDY), 32'd0);
        end

        // Handshake with two entries queued, stale ACK held high
        do_reset();
        t0 = cyc + 5;
        beat_at(t0);
        beat_at(t0 + 300);
        beat_at(t0 + 700);
        tick(10);
        check("hs_rdy1",  32'(IO_READ_RDY), 32'd1);
        check("hs_data1", IO_HEARTBEAT,     32'h0000_012C);
        IO_READ_ACK = 1'b1;
        @(negedge HCLK);
        check("hs_rdy_drop", 32'(IO_READ_RDY), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge HCLK);
            if (IO_READ_RDY) seen = 1'b1;
        end
        check("hs_stale_ack", 32'(seen), 32'd0);
        IO_READ_ACK = 1'b0;
        @(negedge HCLK);
        check("hs_rel_gap", 32'(IO_READ_RDY), 32'd0);
        @(negedge HCLK);
        check("hs_rdy2",  32'(IO_READ_RDY), 32'd1);
        check("hs_data2", IO_HEARTBEAT,     32'h0000_0190);
        ack_entry("hs_ack2");
        tick(5);
        check("hs_empty", 32'(IO_READ_RDY), 32'd0);

        // Reset mid-PRESENT with two entries queued
        do_reset();
        t0 = cyc + 5;
        beat_at(t0);
        beat_at(t0 + 300);
        beat_at(t0 + 700);
        tick(10);
        check("mr_rdy_before", 32'(IO_READ_RDY), 32'd1);
        #2;
        HRESETn = 1'b0;
        #1;
        check("mr_rdy",  32'(IO_READ_RDY), 32'd0);
        check("mr_hb",   IO_HEARTBEAT,     32'h0);
        check("mr_full", 32'(fifo_full),   32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        tick(2);
        t1 = cyc + 5;
        beat_at(t1);
        tick(100);
        check("mr_one_beat", 32'(IO_READ_RDY), 32'd0);
        beat_at(t1 + 400);
        wait_rdy("mr_rdy_after", 20);
        check("mr_data_after", IO_HEARTBEAT, 32'h0000_0190);
        ack_entry("mr_ack");

        // Timeout, then re-arm
        do_reset();
        t0 = cyc + 5;
        beat_at(t0);
        while (cyc < t0 + 2990) @(negedge HCLK);
        check("tmo_early", 32'(IO_READ_RDY), 32'd0);
        wait_rdy("tmo_rdy", 40);
        check("tmo_data", IO_HEARTBEAT, 32'h8000_0BB8);
        ack_entry("tmo_ack");
        tick(20);
        check("tmo_once", 32'(IO_READ_RDY), 32'd0);
        t1 = cyc + 200;
        beat_at(t1);
        tick(300);
        check("tmo_rearm_no_entry", 32'(IO_READ_RDY), 32'd0);
        beat_at(t1 + 600);
        wait_rdy("tmo_next_rdy", 20);
        check("tmo_next_data", IO_HEARTBEAT, 32'h0000_0258);
        ack_entry("tmo_next_ack");

        // Overflow: six intervals into a four-deep FIFO
        do_reset();
        t0 = cyc + 5;
        for (int k = 0; k < 7; k++) beat_at(t0 + 500 * k);
        tick(10);
        check("ovf_full", 32'(fifo_full),   32'd1);
        check("ovf_rdy",  32'(IO_READ_RDY), 32'd1);
        for (int k = 0; k < 4; k++) begin
            wait_rdy($sformatf("ovf_drain%0d_rdy", k), 10);
            check($sformatf("ovf_drain%0d_data", k), IO_HEARTBEAT, 32'h0000_01F4);
            ack_entry($sformatf("ovf_drain%0d_ack", k));
        end
        tick(5);
        check("ovf_drained_full", 32'(fifo_full),   32'd0);
        check("ovf_drained_rdy",  32'(IO_READ_RDY), 32'd0);
        beat_at(t0 + 3500);
        wait_rdy("ovf_dropped_rdy", 20);
        check("ovf_dropped_data", IO_HEARTBEAT, 32'h4000_01F4);
        ack_entry("ovf_dropped_ack");
        beat_at(t0 + 4000);
        wait_rdy("ovf_clean_rdy", 20);
        check("ovf_clean_data", IO_HEARTBEAT, 32'h0000_01F4);
        ack_entry("ovf_clean_ack");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
